// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream (LEN, 2*LEN data bytes, CSUM), assembles
// 16-bit instructions, writes them into instruction memory and holds the core while loading.
module prog_loader #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DEPTH   = 64
) (
  input  logic               clka,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               we_ins,
  output logic [INSTR_W-1:0] load,
  output logic [ADDR_W-1:0]  load_addr,
  output logic               core_hold,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // One extra counter bit lets a full-depth frame terminate without wrapping.
  localparam int unsigned CntW = ADDR_W + 1;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StHi,
    StLo,
    StWrite,
    StCsum,
    StDone,
    StErr
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CntW-1:0]     len_q, len_d;
  logic [7:0]          sum_q, sum_d;
  logic [7:0]          hi_q, hi_d;
  logic [INSTR_W-1:0]  load_q, load_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                accept;
  logic                len_bad;

  assign accept  = byte_valid && byte_ready;
  assign len_bad = (byte_in == 8'd0) || (32'(byte_in) > DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sum_d   = sum_q;
    hi_d    = hi_q;
    load_d  = load_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLen;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      StLen: begin
        if (accept) begin
          len_d   = CntW'(byte_in);
          state_d = len_bad ? StErr : StHi;
        end
      end
      StHi: begin
        if (accept) begin
          hi_d    = byte_in;
          sum_d   = sum_q + byte_in;
          state_d = StLo;
        end
      end
      StLo: begin
        if (accept) begin
          sum_d   = sum_q + byte_in;
          // Word and address are registered here so they are stable during WRITE and after.
          load_d  = INSTR_W'({hi_q, byte_in});
          addr_d  = cnt_q[ADDR_W-1:0];
          state_d = StWrite;
        end
      end
      StWrite: begin
        cnt_d   = cnt_q + CntW'(1);
        state_d = (cnt_d == len_q) ? StCsum : StHi;
      end
      StCsum: begin
        if (accept) begin
          state_d = (byte_in == sum_q) ? StDone : StErr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      hi_q    <= '0;
      load_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      hi_q    <= hi_d;
      load_q  <= load_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    byte_ready = (state_q == StLen) || (state_q == StHi) ||
                 (state_q == StLo)  || (state_q == StCsum);
    busy       = byte_ready || (state_q == StWrite);
    we_ins     = (state_q == StWrite);
    core_hold  = busy || (state_q == StErr);
    done       = (state_q == StDone);
    err        = (state_q == StErr);
    load       = load_q;
    load_addr  = addr_q;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus randomized frames and stalls,
// checked against a frame-level reference model.
module tb_prog_loader;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 6;
  localparam int DEPTH   = 64;

  logic               clka = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [7:0]         byte_in = 8'h00;
  logic               byte_valid = 1'b0;
  logic               byte_ready;
  logic               we_ins;
  logic [INSTR_W-1:0] load;
  logic [ADDR_W-1:0]  load_addr;
  logic               core_hold;
  logic               busy;
  logic               done;
  logic               err;

  prog_loader #(
    .INSTR_W(INSTR_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clka      (clka),
    .reset     (reset),
    .start     (start),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .we_ins    (we_ins),
    .load      (load),
    .load_addr (load_addr),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clka = ~clka;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]                  tx_q[$];
  logic [ADDR_W+INSTR_W-1:0]   exp_wr[$];
  logic [ADDR_W+INSTR_W-1:0]   wr_q[$];
  logic [15:0]                 words_q[$];
  bit                          exp_done;
  int                          ready_in_write = 0;

  // Observed writes, sampled mid-cycle.
  always @(negedge clka) begin
    if (we_ins === 1'b1) begin
      wr_q.push_back({load_addr, load});
      if (byte_ready !== 1'b0) ready_in_write++;
    end
  end

  // Reference model: frame bytes, expected writes and outcome from LEN and words_q.
  task automatic model_frame(input int n, input bit bad);
    int s;
    logic [15:0] w;
    tx_q.delete();
    exp_wr.delete();
    tx_q.push_back(8'(n));
    if (n < 1 || n > DEPTH) begin
      exp_done = 1'b0;
      return;
    end
    s = 0;
    for (int k = 0; k < n; k++) begin
      w = words_q[k];
      tx_q.push_back(w[15:8]);
      tx_q.push_back(w[7:0]);
      s = s + int'(w[15:8]) + int'(w[7:0]);
      exp_wr.push_back({6'(k), w});
    end
    tx_q.push_back(8'((s + (bad ? 1 : 0)) % 256));
    exp_done = !bad;
  endtask

  task automatic random_words(input int n);
    words_q.delete();
    for (int k = 0; k < n; k++) words_q.push_back(16'($urandom));
  endtask

  // Sends start then up to max_bytes of tx_q; valid stays high between bytes unless stalled.
  task automatic drive_frame(input int stall_pct, input int max_bytes, output bit tmo);
    int cyc;
    tmo = 1'b0;
    wr_q.delete();
    ready_in_write = 0;
    start = 1'b1;
    @(posedge clka);
    #1 start = 1'b0;
    for (int i = 0; i < tx_q.size() && i < max_bytes; i++) begin
      if (int'($urandom_range(99)) < stall_pct) begin
        byte_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clka);
        #1;
      end
      byte_in    = tx_q[i];
      byte_valid = 1'b1;
      cyc = 0;
      @(negedge clka);
      while (byte_ready !== 1'b1 && cyc < 64) begin
        cyc++;
        @(negedge clka);
      end
      if (byte_ready !== 1'b1) begin
        tmo = 1'b1;
        break;
      end
      @(posedge clka);
      #1;
    end
    byte_valid = 1'b0;
    repeat (3) @(posedge clka);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3 reset = 1'b0;
    #10;
    n_cmp++;
    if ({we_ins, load, load_addr, core_hold, busy, done, err, byte_ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0",
               {we_ins, load, load_addr, core_hold, busy, done, err, byte_ready});
    end
    @(negedge clka) reset = 1'b1;
    @(posedge clka);
    #1;
    n_cmp++;
    if ({busy, core_hold, byte_ready} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %b expected 000", {busy, core_hold, byte_ready});
    end
  endtask

  task automatic test_basic();
    bit tmo;
    tx_q   = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
    exp_wr = '{{6'd0, 16'h1234}, {6'd1, 16'hABCD}};
    drive_frame(0, 1000, tmo);
    n_cmp++;
    if (tmo) begin n_bad++; $display("FAIL basic_timeout: byte not accepted in budget"); end
    n_cmp++;
    if (wr_q.size() != 2) begin
      n_bad++;
      $display("FAIL basic_wr_count: got %0d expected 2", wr_q.size());
    end
    for (int i = 0; i < 2 && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i] !== exp_wr[i]) begin
        n_bad++;
        $display("FAIL basic_write%0d: got %h expected %h", i, wr_q[i], exp_wr[i]);
      end
    end
    n_cmp++;
    if (ready_in_write != 0) begin
      n_bad++;
      $display("FAIL basic_ready_in_write: got %0d expected 0", ready_in_write);
    end
    n_cmp++;
    if ({done, err, core_hold, busy} !== 4'b1000) begin
      n_bad++;
      $display("FAIL basic_status: got %b expected 1000", {done, err, core_hold, busy});
    end
  endtask

  task automatic test_bad_csum();
    bit tmo;
    words_q = '{16'h1234, 16'hABCD};
    model_frame(2, 1'b1);
    drive_frame(0, 1000, tmo);
    n_cmp++;
    if (tx_q[5] !== 8'hBF) begin
      n_bad++;
      $display("FAIL badcsum_byte: got %h expected bf", tx_q[5]);
    end
    n_cmp++;
    if ({done, err, core_hold, busy, tmo} !== 5'b01100) begin
      n_bad++;
      $display("FAIL badcsum_status: got %b expected 01100", {done, err, core_hold, busy, tmo});
    end
    model_frame(2, 1'b0);
    drive_frame(0, 1000, tmo);
    n_cmp++;
    if ({done, err, core_hold, busy, tmo} !== 5'b10000) begin
      n_bad++;
      $display("FAIL recover_status: got %b expected 10000", {done, err, core_hold, busy, tmo});
    end
    n_cmp++;
    if (wr_q.size() != 2 || wr_q[0] !== {6'd0, 16'h1234}) begin
      n_bad++;
      $display("FAIL recover_writes: got %0d writes expected 2 from addr 0", wr_q.size());
    end
  endtask

  task automatic test_length_bounds();
    bit tmo;
    int lens[3];
    lens = '{0, 65, int'($urandom_range(66, 255))};
    for (int j = 0; j < 3; j++) begin
      random_words(1);
      model_frame(lens[j], 1'b0);
      drive_frame(0, 1000, tmo);
      n_cmp++;
      if (wr_q.size() != 0) begin
        n_bad++;
        $display("FAIL len%0d_writes: got %0d expected 0", lens[j], wr_q.size());
      end
      n_cmp++;
      if ({done, err, core_hold, busy, tmo} !== 5'b01100) begin
        n_bad++;
        $display("FAIL len%0d_status: got %b expected 01100", lens[j],
                 {done, err, core_hold, busy, tmo});
      end
    end
  endtask

  task automatic test_full_depth();
    bit tmo;
    words_q.delete();
    for (int k = 0; k < DEPTH; k++) words_q.push_back({8'(k), ~8'(k)});
    model_frame(DEPTH, 1'b0);
    drive_frame(0, 1000, tmo);
    n_cmp++;
    if (wr_q.size() != DEPTH || tmo) begin
      n_bad++;
      $display("FAIL full_wr_count: got %0d expected %0d", wr_q.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i] !== exp_wr[i]) begin
        n_bad++;
        $display("FAIL full_write%0d: got %h expected %h", i, wr_q[i], exp_wr[i]);
      end
    end
    n_cmp++;
    if ({done, err, core_hold} !== 3'b100) begin
      n_bad++;
      $display("FAIL full_status: got %b expected 100", {done, err, core_hold});
    end
  endtask

  task automatic test_random_stalls();
    bit tmo;
    int n;
    bit bad;
    for (int t = 0; t < 8; t++) begin
      n   = int'($urandom_range(1, DEPTH));
      bad = (t % 3 == 2);
      random_words(n);
      model_frame(n, bad);
      drive_frame(35, 1000, tmo);
      n_cmp++;
      if (wr_q.size() != exp_wr.size() || tmo) begin
        n_bad++;
        $display("FAIL rand%0d_wr_count: got %0d expected %0d", t, wr_q.size(), exp_wr.size());
      end
      for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
        n_cmp++;
        if (wr_q[i] !== exp_wr[i]) begin
          n_bad++;
          $display("FAIL rand%0d_write%0d: got %h expected %h", t, i, wr_q[i], exp_wr[i]);
        end
      end
      n_cmp++;
      if ({done, err, core_hold, ready_in_write != 0} !== {exp_done, !exp_done, !exp_done, 1'b0})
      begin
        n_bad++;
        $display("FAIL rand%0d_status: got %b expected %b", t,
                 {done, err, core_hold, ready_in_write != 0},
                 {exp_done, !exp_done, !exp_done, 1'b0});
      end
    end
  endtask

  task automatic test_async_reset();
    bit tmo;
    random_words(4);
    words_q[0] = words_q[0] | 16'h8000;
    model_frame(4, 1'b0);
    // LEN, HI0, LO0, HI1: word 0 has been written, loader now waits in LO.
    drive_frame(0, 4, tmo);
    n_cmp++;
    if ({load, core_hold, busy, tmo} !== {words_q[0], 3'b110}) begin
      n_bad++;
      $display("FAIL midframe_before: got %h expected %h", {load, core_hold, busy, tmo},
               {words_q[0], 3'b110});
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({we_ins, load, load_addr, core_hold, busy, done, err, byte_ready} !== '0) begin
      n_bad++;
      $display("FAIL async_reset_outputs: got %h expected 0",
               {we_ins, load, load_addr, core_hold, busy, done, err, byte_ready});
    end
    @(negedge clka) reset = 1'b1;
    @(posedge clka);
    #1;
    random_words(3);
    model_frame(3, 1'b0);
    drive_frame(20, 1000, tmo);
    n_cmp++;
    if (wr_q.size() != 3 || tmo) begin
      n_bad++;
      $display("FAIL after_reset_wr_count: got %0d expected 3", wr_q.size());
    end
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i] !== exp_wr[i]) begin
        n_bad++;
        $display("FAIL after_reset_write%0d: got %h expected %h", i, wr_q[i], exp_wr[i]);
      end
    end
    n_cmp++;
    if ({done, err, core_hold} !== 3'b100) begin
      n_bad++;
      $display("FAIL after_reset_status: got %b expected 100", {done, err, core_hold});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_length_bounds();
    test_full_depth();
    test_random_stalls();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
